// File: rtl/deblock_pkg.sv
// Shared types and constants for the deblocking edge scheduler.
//
// Contents:
//   edge_dir_e      direction of a block edge presented to the filter engine
//   sched_state_e   frame-walk state of the scheduler FSM
//   CNT_W           width of the outstanding-job counter (supports up to 15 in flight)
//   is_issue_state  true for the states that offer jobs on the job port
package deblock_pkg;

  typedef enum logic {
    EDGE_VERT = 1'b0,
    EDGE_HORZ = 1'b1
  } edge_dir_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VERT  = 2'd1,
    HORZ  = 2'd2,
    DRAIN = 2'd3
  } sched_state_e;

  localparam int CNT_W = 4;

  function automatic logic is_issue_state(sched_state_e s);
    return (s == VERT) || (s == HORZ);
  endfunction

endpackage

// File: rtl/deblock_credit_ctr.sv
// Outstanding-job credit counter for the deblocking edge scheduler.
//
// Ports:
//   clk        in   clock, all logic on posedge
//   reset      in   synchronous active-high reset
//   inc        in   a job was accepted by the engine this cycle
//   dec        in   the engine reported a completion this cycle
//   can_issue  out  count after this cycle's update is below MAX_OUTSTANDING
//   is_zero    out  registered count is zero
//   err        out  sticky: a completion arrived while the count was zero
module deblock_credit_ctr
  import deblock_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic can_issue,
  output logic is_zero,
  output logic err
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;
  logic             underflow;

  // A completion with nothing outstanding is flagged and otherwise ignored,
  // so the count never wraps. Accept plus completion together cancel out.
  always_comb begin
    underflow = dec && (count_q == '0);
    count_d   = count_q;
    if (inc && !dec) begin
      count_d = count_q + CNT_W'(1);
    end else if (dec && !inc && !underflow) begin
      count_d = count_q - CNT_W'(1);
    end
    err_d = err_q | underflow;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Looking at the post-update count lets the scheduler raise job_valid in
  // the cycle right after an accept or completion without overshooting.
  assign can_issue = (32'(count_d) < MAX_OUTSTANDING);
  assign is_zero   = (count_q == '0);
  assign err       = err_q;

endmodule

// File: rtl/deblock_edge_scheduler.sv
// Deblocking filter edge scheduler: walks one frame in N x N blocks and
// offers one filter job per internal block edge over a valid/ready port,
// limiting jobs in flight with a credit counter and pulsing frame_done once
// every issued job has completed.
//
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   start          frame start request, honoured in IDLE only
//   busy           frame in progress (cycle after start until frame_done)
//   frame_done     one-cycle pulse after the last job has completed
//   job_valid      job offered; job_dir/job_x/job_y hold until accepted
//   job_ready      engine accepts when job_valid && job_ready
//   job_dir        0 = vertical edge, 1 = horizontal edge
//   job_x, job_y   edge coordinates in pixels
//   cmpl_valid     one pulse per completed job
//   err_cmpl       sticky completion-underflow flag
//   stall_cycles   (DEBLOCK_STALL_CNT_EN only) saturating count of cycles
//                  with job_valid && !job_ready, cleared on start
//
// Optional feature macro: DEBLOCK_STALL_CNT_EN
module deblock_edge_scheduler
  import deblock_pkg::*;
#(
  parameter  int WIDTH           = 640,
  parameter  int HEIGHT          = 480,
  parameter  int N               = 8,
  parameter  int MAX_OUTSTANDING = 4,
  localparam int XW              = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  localparam int YW              = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          frame_done,
  output logic          job_valid,
  input  logic          job_ready,
  output logic          job_dir,
  output logic [XW-1:0] job_x,
  output logic [YW-1:0] job_y,
  input  logic          cmpl_valid,
  output logic          err_cmpl
`ifdef DEBLOCK_STALL_CNT_EN
  ,
  output logic [31:0]   stall_cycles
`endif
);

  localparam int BW = WIDTH / N;
  localparam int BH = HEIGHT / N;

  if ((WIDTH % N) != 0) begin : g_bad_width
    $fatal(1, "deblock_edge_scheduler: WIDTH must be a multiple of N");
  end
  if ((HEIGHT % N) != 0) begin : g_bad_height
    $fatal(1, "deblock_edge_scheduler: HEIGHT must be a multiple of N");
  end
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 15) begin : g_bad_max
    $fatal(1, "deblock_edge_scheduler: MAX_OUTSTANDING must be 1..15");
  end

  sched_state_e  state_q, state_d;
  logic [XW-1:0] bx_q, bx_d;
  logic [YW-1:0] by_q, by_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;
  logic          job_valid_q, job_valid_d;
  edge_dir_e     job_dir_q, job_dir_d;
  logic [XW-1:0] job_x_q, job_x_d;
  logic [YW-1:0] job_y_q, job_y_d;

  logic accept;
  logic can_issue;
  logic cnt_zero;
  logic bx_last;
  logic by_last;
  logic by_zero;

  assign accept  = job_valid_q && job_ready;
  assign bx_last = (32'(bx_q) == BW - 1);
  assign by_last = (32'(by_q) == BH - 1);
  assign by_zero = (by_q == '0);

  deblock_credit_ctr #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_credit (
    .clk      (clk),
    .reset    (reset),
    .inc      (accept),
    .dec      (cmpl_valid),
    .can_issue(can_issue),
    .is_zero  (cnt_zero),
    .err      (err_cmpl)
  );

  // Frame walk. bx/by always point at the job currently offered (or about
  // to be offered), so the cursor only advances on an accept. Empty phases
  // are skipped within the same transition: VERT is empty when BW==1 and
  // HORZ is empty in block row 0.
  always_comb begin
    state_d      = state_q;
    bx_d         = bx_q;
    by_d         = by_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          by_d   = '0;
          bx_d   = '0;
          if (BW > 1) begin
            state_d = VERT;
            bx_d    = XW'(1);
          end else if (BH > 1) begin
            state_d = HORZ;
            by_d    = YW'(1);
          end else begin
            state_d = DRAIN;
          end
        end
      end

      VERT: begin
        if (accept) begin
          if (!bx_last) begin
            bx_d = bx_q + XW'(1);
          end else if (!by_zero) begin
            state_d = HORZ;
            bx_d    = '0;
          end else if (BH > 1) begin
            by_d = by_q + YW'(1);
            bx_d = XW'(1);
          end else begin
            state_d = DRAIN;
          end
        end
      end

      HORZ: begin
        if (accept) begin
          if (!bx_last) begin
            bx_d = bx_q + XW'(1);
          end else if (by_last) begin
            state_d = DRAIN;
          end else begin
            by_d = by_q + YW'(1);
            if (BW > 1) begin
              state_d = VERT;
              bx_d    = XW'(1);
            end else begin
              bx_d = '0;
            end
          end
        end
      end

      DRAIN: begin
        if (cnt_zero) begin
          state_d      = IDLE;
          busy_d       = 1'b0;
          frame_done_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Job port. An offered job is frozen until accepted; a new offer is only
  // raised when the credit counter still has room after this cycle's update.
  always_comb begin
    job_valid_d = job_valid_q;
    job_dir_d   = job_dir_q;
    job_x_d     = job_x_q;
    job_y_d     = job_y_q;
    if (!job_valid_q || accept) begin
      job_valid_d = is_issue_state(state_d) && can_issue;
      if (job_valid_d) begin
        job_dir_d = (state_d == HORZ) ? EDGE_HORZ : EDGE_VERT;
        job_x_d   = XW'(32'(bx_d) * N);
        job_y_d   = YW'(32'(by_d) * N);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      bx_q         <= '0;
      by_q         <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      job_valid_q  <= 1'b0;
      job_dir_q    <= EDGE_VERT;
      job_x_q      <= '0;
      job_y_q      <= '0;
    end else begin
      state_q      <= state_d;
      bx_q         <= bx_d;
      by_q         <= by_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      job_valid_q  <= job_valid_d;
      job_dir_q    <= job_dir_d;
      job_x_q      <= job_x_d;
      job_y_q      <= job_y_d;
    end
  end

  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign job_valid  = job_valid_q;
  assign job_dir    = job_dir_q;
  assign job_x      = job_x_q;
  assign job_y      = job_y_q;

`ifdef DEBLOCK_STALL_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  // Back-pressure counter: restarts with each frame and keeps its final
  // value after frame_done so it can be read at leisure.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if ((state_q == IDLE) && start) begin
      stall_cycles_d = '0;
    end else if (job_valid_q && !job_ready && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_deblock_edge_scheduler.sv
// Self-checking bench for deblock_edge_scheduler. Four instances cover the
// default 640x480 frame, a MAX_OUTSTANDING=2 variant, a 16x16 frame driven
// from a per-cycle vector table, and a single-block (zero-job) frame.
// Inputs are driven 1 time unit after each rising edge and outputs are
// sampled at the same point, clear of the active edge.
module tb_deblock_edge_scheduler;

  logic clk;
  logic reset;

  // default instance 640x480, MAX_OUTSTANDING=4
  logic       def_start, def_busy, def_done, def_valid, def_ready, def_dir, def_cmpl, def_err;
  logic [9:0] def_x;
  logic [8:0] def_y;
  // MAX_OUTSTANDING=2 instance
  logic       m2_start, m2_busy, m2_done, m2_valid, m2_ready, m2_dir, m2_cmpl, m2_err;
  logic [9:0] m2_x;
  logic [8:0] m2_y;
  // 16x16 instance
  logic       sm_start, sm_busy, sm_done, sm_valid, sm_ready, sm_dir, sm_cmpl, sm_err;
  logic [3:0] sm_x;
  logic [3:0] sm_y;
  // 8x8 instance (no internal edges)
  logic       zr_start, zr_busy, zr_done, zr_valid, zr_ready, zr_dir, zr_cmpl, zr_err;
  logic [2:0] zr_x;
  logic [2:0] zr_y;
`ifdef DEBLOCK_STALL_CNT_EN
  logic [31:0] def_stall, m2_stall, sm_stall, zr_stall;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic start;
    logic ready;
    logic cmpl;
    int   valid;
    int   dir;
    int   x;
    int   y;
    int   busy;
    int   done;
    int   err;
    logic chk_job;
  } vec_t;

  typedef struct {
    int dir;
    int x;
    int y;
  } job_t;

  vec_t vecs[12];
  job_t exp_q[$];

  deblock_edge_scheduler u_def (
    .clk(clk), .reset(reset), .start(def_start), .busy(def_busy), .frame_done(def_done),
    .job_valid(def_valid), .job_ready(def_ready), .job_dir(def_dir), .job_x(def_x),
    .job_y(def_y), .cmpl_valid(def_cmpl), .err_cmpl(def_err)
`ifdef DEBLOCK_STALL_CNT_EN
    , .stall_cycles(def_stall)
`endif
  );

  deblock_edge_scheduler #(.MAX_OUTSTANDING(2)) u_m2 (
    .clk(clk), .reset(reset), .start(m2_start), .busy(m2_busy), .frame_done(m2_done),
    .job_valid(m2_valid), .job_ready(m2_ready), .job_dir(m2_dir), .job_x(m2_x),
    .job_y(m2_y), .cmpl_valid(m2_cmpl), .err_cmpl(m2_err)
`ifdef DEBLOCK_STALL_CNT_EN
    , .stall_cycles(m2_stall)
`endif
  );

  deblock_edge_scheduler #(.WIDTH(16), .HEIGHT(16), .N(8)) u_sm (
    .clk(clk), .reset(reset), .start(sm_start), .busy(sm_busy), .frame_done(sm_done),
    .job_valid(sm_valid), .job_ready(sm_ready), .job_dir(sm_dir), .job_x(sm_x),
    .job_y(sm_y), .cmpl_valid(sm_cmpl), .err_cmpl(sm_err)
`ifdef DEBLOCK_STALL_CNT_EN
    , .stall_cycles(sm_stall)
`endif
  );

  deblock_edge_scheduler #(.WIDTH(8), .HEIGHT(8), .N(8)) u_zr (
    .clk(clk), .reset(reset), .start(zr_start), .busy(zr_busy), .frame_done(zr_done),
    .job_valid(zr_valid), .job_ready(zr_ready), .job_dir(zr_dir), .job_x(zr_x),
    .job_y(zr_y), .cmpl_valid(zr_cmpl), .err_cmpl(zr_err)
`ifdef DEBLOCK_STALL_CNT_EN
    , .stall_cycles(zr_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic vec_t mkVec(input logic st, input logic rd, input logic cm,
                                 input int v, input int d, input int x, input int y,
                                 input int b, input int dn, input int e, input logic cj);
    vec_t r;
    r.start = st; r.ready = rd; r.cmpl = cm;
    r.valid = v; r.dir = d; r.x = x; r.y = y;
    r.busy = b; r.done = dn; r.err = e; r.chk_job = cj;
    return r;
  endfunction

  task automatic applyStimulus(input vec_t v);
    sm_start = v.start;
    sm_ready = v.ready;
    sm_cmpl  = v.cmpl;
    tick();
  endtask

  task automatic checkDefReset(input string tag);
    checkOutput({tag, " busy"}, int'(def_busy), 0);
    checkOutput({tag, " frame_done"}, int'(def_done), 0);
    checkOutput({tag, " job_valid"}, int'(def_valid), 0);
    checkOutput({tag, " job_dir"}, int'(def_dir), 0);
    checkOutput({tag, " job_x"}, int'(def_x), 0);
    checkOutput({tag, " job_y"}, int'(def_y), 0);
    checkOutput({tag, " err_cmpl"}, int'(def_err), 0);
`ifdef DEBLOCK_STALL_CNT_EN
    checkOutput({tag, " stall_cycles"}, int'(def_stall), 0);
`endif
  endtask

  initial begin
    int acc_cnt;
    int order_err;
    int done_cnt;
    int cyc;
    int first_job;
    int first_horz;
    int last_job;
    int m2_acc;
    int m2_done_seen;
    logic acc;
    logic finished;

    reset = 1'b1;
    def_start = 0; def_ready = 0; def_cmpl = 0;
    m2_start = 0;  m2_ready = 0;  m2_cmpl = 0;
    sm_start = 0;  sm_ready = 0;  sm_cmpl = 0;
    zr_start = 0;  zr_ready = 0;  zr_cmpl = 0;

    // expected edge order for the 640x480 frame (BW=80, BH=60)
    for (int by = 0; by < 60; by++) begin
      for (int bx = 1; bx < 80; bx++) exp_q.push_back('{0, bx * 8, by * 8});
      if (by > 0) for (int bx = 0; bx < 80; bx++) exp_q.push_back('{1, bx * 8, by * 8});
    end

    // 16x16 per-cycle table: start, ready, cmpl | valid, dir, x, y, busy, done, err, check fields
    vecs[0]  = mkVec(1, 1, 0, 1, 0, 8, 0, 1, 0, 0, 1);
    vecs[1]  = mkVec(0, 1, 0, 1, 0, 8, 8, 1, 0, 0, 1);
    vecs[2]  = mkVec(0, 1, 1, 1, 1, 0, 8, 1, 0, 0, 1);
    vecs[3]  = mkVec(1, 1, 0, 1, 1, 8, 8, 1, 0, 0, 1);
    vecs[4]  = mkVec(0, 0, 1, 1, 1, 8, 8, 1, 0, 0, 1);
    vecs[5]  = mkVec(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    vecs[6]  = mkVec(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    vecs[7]  = mkVec(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    vecs[8]  = mkVec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    vecs[9]  = mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[10] = mkVec(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    vecs[11] = mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

    tick(); tick();
    checkDefReset("reset");
    reset = 1'b0;
    tick();
    checkDefReset("idle");

    // zero-job frame
    $display("[TB] zero-job frame");
    zr_start = 1; tick(); zr_start = 0;
    checkOutput("zero t+1 busy", int'(zr_busy), 1);
    checkOutput("zero t+1 done", int'(zr_done), 0);
    checkOutput("zero t+1 valid", int'(zr_valid), 0);
    tick();
    checkOutput("zero t+2 busy", int'(zr_busy), 0);
    checkOutput("zero t+2 done", int'(zr_done), 1);
    tick();
    checkOutput("zero t+3 done", int'(zr_done), 0);

    // 16x16 table
    $display("[TB] 16x16 vector table");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d valid", i), int'(sm_valid), vecs[i].valid);
      checkOutput($sformatf("vec%0d busy", i), int'(sm_busy), vecs[i].busy);
      checkOutput($sformatf("vec%0d done", i), int'(sm_done), vecs[i].done);
      checkOutput($sformatf("vec%0d err", i), int'(sm_err), vecs[i].err);
      if (vecs[i].chk_job) begin
        checkOutput($sformatf("vec%0d dir", i), int'(sm_dir), vecs[i].dir);
        checkOutput($sformatf("vec%0d x", i), int'(sm_x), vecs[i].x);
        checkOutput($sformatf("vec%0d y", i), int'(sm_y), vecs[i].y);
      end
    end
    sm_cmpl = 0;

    // simultaneous accept and completion with one job outstanding
    $display("[TB] credit accounting, MAX_OUTSTANDING=2");
    m2_start = 1; tick(); m2_start = 0;
    checkOutput("m2 first valid", int'(m2_valid), 1);
    checkOutput("m2 first x", int'(m2_x), 8);
    m2_ready = 1; tick();
    checkOutput("m2 second valid", int'(m2_valid), 1);
    checkOutput("m2 second x", int'(m2_x), 16);
    m2_cmpl = 1; tick();
    checkOutput("m2 acc+cmpl valid", int'(m2_valid), 1);
    checkOutput("m2 acc+cmpl x", int'(m2_x), 24);
    checkOutput("m2 acc+cmpl err", int'(m2_err), 0);
    m2_cmpl = 0; tick();
    checkOutput("m2 credits full valid", int'(m2_valid), 0);
    m2_ready = 0; tick();
    checkOutput("m2 still full valid", int'(m2_valid), 0);
    m2_cmpl = 1; tick(); m2_cmpl = 0;
    checkOutput("m2 credit back valid", int'(m2_valid), 1);
    checkOutput("m2 credit back x", int'(m2_x), 32);

    reset = 1; tick(); reset = 0;

    // engine never completes: only MAX_OUTSTANDING accepts
    $display("[TB] MAX_OUTSTANDING=2 without completions");
    m2_acc = 0; m2_done_seen = 0;
    m2_start = 1; m2_ready = 1; tick(); m2_start = 0;
    for (int i = 0; i < 40; i++) begin
      if (m2_valid && m2_ready) m2_acc++;
      tick();
      if (m2_done) m2_done_seen++;
    end
    checkOutput("m2 accepts", m2_acc, 2);
    checkOutput("m2 valid parked", int'(m2_valid), 0);
    checkOutput("m2 busy held", int'(m2_busy), 1);
    checkOutput("m2 no frame_done", m2_done_seen, 0);
    m2_ready = 0;

    // back-pressure: fields stable while job_ready is low
    $display("[TB] back-pressure hold");
    def_start = 1; def_ready = 0; tick(); def_start = 0;
    checkOutput("bp first valid", int'(def_valid), 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("bp%0d valid", i), int'(def_valid), 1);
      checkOutput($sformatf("bp%0d dir", i), int'(def_dir), 0);
      checkOutput($sformatf("bp%0d x", i), int'(def_x), 8);
      checkOutput($sformatf("bp%0d y", i), int'(def_y), 0);
    end
`ifdef DEBLOCK_STALL_CNT_EN
    checkOutput("bp stall_cycles", int'(def_stall), 5);
`endif

    // full default frame, completion one cycle after each accept
    $display("[TB] full 640x480 frame");
    def_ready = 1;
    acc_cnt = 0; order_err = 0; done_cnt = 0; cyc = 0; finished = 0;
    first_job = -1; first_horz = -1; last_job = -1;
    while (!finished && cyc < 20000) begin
      acc = def_valid && def_ready;
      if (acc) begin
        int packed_job;
        packed_job = (int'(def_dir) << 20) | (int'(def_x) << 10) | int'(def_y);
        if (acc_cnt < exp_q.size()) begin
          if (int'(def_dir) != exp_q[acc_cnt].dir || int'(def_x) != exp_q[acc_cnt].x ||
              int'(def_y) != exp_q[acc_cnt].y) order_err++;
        end else begin
          order_err++;
        end
        if (first_job < 0) first_job = packed_job;
        if (first_horz < 0 && def_dir) first_horz = packed_job;
        last_job = packed_job;
        acc_cnt++;
      end
      tick();
      def_cmpl = acc;
      if (def_done) done_cnt++;
      if (done_cnt > 0 && !def_cmpl && !def_valid) finished = 1;
      cyc++;
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      def_cmpl = 0;
      if (def_done) done_cnt++;
    end
    checkOutput("frame finished in budget", int'(finished), 1);
    checkOutput("frame accepts", acc_cnt, 9460);
    checkOutput("frame order errors", order_err, 0);
    checkOutput("first job", first_job, (0 << 20) | (8 << 10) | 0);
    checkOutput("first horz job", first_horz, (1 << 20) | (0 << 10) | 8);
    checkOutput("last job", last_job, (1 << 20) | (632 << 10) | 472);
    checkOutput("frame_done pulses", done_cnt, 1);
    checkOutput("frame busy after done", int'(def_busy), 0);
    checkOutput("frame err_cmpl", int'(def_err), 0);
`ifdef DEBLOCK_STALL_CNT_EN
    checkOutput("stall held after done", int'(def_stall), 5);
`endif

    // reset mid-frame, then replay
    $display("[TB] reset mid-frame");
    def_start = 1; def_ready = 1; tick(); def_start = 0;
    acc_cnt = 0; cyc = 0;
    while (acc_cnt < 100 && cyc < 1000) begin
      acc = def_valid && def_ready;
      if (acc) acc_cnt++;
      tick();
      def_cmpl = acc;
      cyc++;
    end
    checkOutput("mid-frame accepts", acc_cnt, 100);
    reset = 1; def_cmpl = 0; def_ready = 0; tick(); reset = 0;
    checkDefReset("after reset");
    def_start = 1; tick(); def_start = 0;
    checkOutput("replay busy", int'(def_busy), 1);
    checkOutput("replay valid", int'(def_valid), 1);
    checkOutput("replay dir", int'(def_dir), 0);
    checkOutput("replay x", int'(def_x), 8);
    checkOutput("replay y", int'(def_y), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
